// File: rtl/ahb_dual_arbiter.sv
// Purpose: merges the AHB-Lite instruction and data masters onto one AHB-Lite slave port.
// Latency: zero added cycles when uncontended; a losing master waits one slave address phase per lost arbitration.
// Backpressure: a losing master's address phase is buffered and the master is held via its hready until that transfer is issued.
module ahb_dual_arbiter #(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic [31:0] s_i_haddr_i,
    input  logic [1:0]  s_i_htrans_i,
    input  logic [5:0]  s_i_hparity_i,
    output logic        s_i_hready_o,
    output logic        s_i_hresp_o,
    output logic [31:0] s_i_hrdata_o,
    output logic [6:0]  s_i_hrchecksum_o,
    input  logic [31:0] s_d_haddr_i,
    input  logic [1:0]  s_d_htrans_i,
    input  logic        s_d_hwrite_i,
    input  logic [2:0]  s_d_hsize_i,
    input  logic [5:0]  s_d_hparity_i,
    input  logic [31:0] s_d_hwdata_i,
    input  logic [6:0]  s_d_hwchecksum_i,
    output logic        s_d_hready_o,
    output logic        s_d_hresp_o,
    output logic [31:0] s_d_hrdata_o,
    output logic [6:0]  s_d_hrchecksum_o,
    output logic [31:0] s_haddr_o,
    output logic [1:0]  s_htrans_o,
    output logic        s_hwrite_o,
    output logic [2:0]  s_hsize_o,
    output logic [5:0]  s_hparity_o,
    output logic [31:0] s_hwdata_o,
    output logic [6:0]  s_hwchecksum_o,
    input  logic [31:0] s_hrdata_i,
    input  logic [6:0]  s_hrchecksum_i,
    input  logic        s_hready_i,
    input  logic        s_hresp_i
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } own_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] SIZE_WORD     = 3'b010;

    // State registers and their next values
    logic        pend_i, pend_i_nxt, pend_d, pend_d_nxt;
    logic [31:0] buf_i_addr, buf_i_addr_nxt, buf_d_addr, buf_d_addr_nxt;
    logic [5:0]  buf_i_parity, buf_i_parity_nxt, buf_d_parity, buf_d_parity_nxt;
    logic        buf_d_write, buf_d_write_nxt;
    logic [2:0]  buf_d_size, buf_d_size_nxt;
    own_t        a_own, a_own_nxt, d_own, d_own_nxt;
    logic        last_d, last_d_nxt;   // 1 = D won the last contended arbitration

    logic live_i, live_d, cand_i, cand_d, both;
    own_t sel;

    // Only htrans[1] matters: the slave side only ever sees IDLE or NONSEQ
    logic unused_htrans;
    assign unused_htrans = s_i_htrans_i[0] ^ s_d_htrans_i[0];

    // Master ready: stalled while buffered, otherwise follows slave only for the data-phase owner
    assign s_i_hready_o = pend_i ? 1'b0 : ((d_own == OWN_I) ? s_hready_i : 1'b1);
    assign s_d_hready_o = pend_d ? 1'b0 : ((d_own == OWN_D) ? s_hready_i : 1'b1);

    assign live_i = s_i_htrans_i[1] & s_i_hready_o;
    assign live_d = s_d_htrans_i[1] & s_d_hready_o;
    assign cand_i = pend_i | live_i;
    assign cand_d = pend_d | live_d;
    assign both   = cand_i & cand_d;

    // Arbitration: a locked address phase wins, else priority or alternation on contention
    always_comb begin
        sel = OWN_NONE;
        if (a_own != OWN_NONE) begin
            sel = a_own;
        end else if (both) begin
            sel = (!ROUND_ROBIN || !last_d) ? OWN_D : OWN_I;
        end else if (cand_d) begin
            sel = OWN_D;
        end else if (cand_i) begin
            sel = OWN_I;
        end
    end

    // Slave address phase: buffered copy takes precedence over live inputs
    always_comb begin
        s_htrans_o  = HTRANS_IDLE;
        s_haddr_o   = 32'd0;
        s_hwrite_o  = 1'b0;
        s_hsize_o   = SIZE_WORD;
        s_hparity_o = 6'd0;
        if (sel == OWN_I) begin
            s_htrans_o  = HTRANS_NONSEQ;
            s_haddr_o   = pend_i ? buf_i_addr : s_i_haddr_i;
            s_hparity_o = pend_i ? buf_i_parity : s_i_hparity_i;
        end else if (sel == OWN_D) begin
            s_htrans_o  = HTRANS_NONSEQ;
            s_haddr_o   = pend_d ? buf_d_addr : s_d_haddr_i;
            s_hwrite_o  = pend_d ? buf_d_write : s_d_hwrite_i;
            s_hsize_o   = pend_d ? buf_d_size : s_d_hsize_i;
            s_hparity_o = pend_d ? buf_d_parity : s_d_hparity_i;
        end
    end

    // Data phase routing to and from the data-phase owner
    assign s_hwdata_o       = (d_own == OWN_D) ? s_d_hwdata_i : 32'd0;
    assign s_hwchecksum_o   = (d_own == OWN_D) ? s_d_hwchecksum_i : 7'd0;
    assign s_i_hrdata_o     = s_hrdata_i;
    assign s_d_hrdata_o     = s_hrdata_i;
    assign s_i_hrchecksum_o = s_hrchecksum_i;
    assign s_d_hrchecksum_o = s_hrchecksum_i;
    assign s_i_hresp_o      = (d_own == OWN_I) ? s_hresp_i : 1'b0;
    assign s_d_hresp_o      = (d_own == OWN_D) ? s_hresp_i : 1'b0;

    // Next state: ownership hand-over on slave ready, address lock on stall, capture of losers
    always_comb begin
        pend_i_nxt       = pend_i;
        pend_d_nxt       = pend_d;
        buf_i_addr_nxt   = buf_i_addr;
        buf_i_parity_nxt = buf_i_parity;
        buf_d_addr_nxt   = buf_d_addr;
        buf_d_parity_nxt = buf_d_parity;
        buf_d_write_nxt  = buf_d_write;
        buf_d_size_nxt   = buf_d_size;
        a_own_nxt        = a_own;
        d_own_nxt        = d_own;
        last_d_nxt       = last_d;
        if (s_hready_i) begin
            d_own_nxt = sel;
            a_own_nxt = OWN_NONE;
            if (sel == OWN_I) pend_i_nxt = 1'b0;
            if (sel == OWN_D) pend_d_nxt = 1'b0;
            if (both) last_d_nxt = (sel == OWN_D);
        end else begin
            a_own_nxt = sel;
        end
        if (live_i && !(s_hready_i && sel == OWN_I)) begin
            pend_i_nxt       = 1'b1;
            buf_i_addr_nxt   = s_i_haddr_i;
            buf_i_parity_nxt = s_i_hparity_i;
        end
        if (live_d && !(s_hready_i && sel == OWN_D)) begin
            pend_d_nxt       = 1'b1;
            buf_d_addr_nxt   = s_d_haddr_i;
            buf_d_parity_nxt = s_d_hparity_i;
            buf_d_write_nxt  = s_d_hwrite_i;
            buf_d_size_nxt   = s_d_hsize_i;
        end
    end

    // State register with asynchronous clear; outstanding transfers are abandoned on reset
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            pend_i       <= 1'b0;
            pend_d       <= 1'b0;
            buf_i_addr   <= 32'd0;
            buf_i_parity <= 6'd0;
            buf_d_addr   <= 32'd0;
            buf_d_parity <= 6'd0;
            buf_d_write  <= 1'b0;
            buf_d_size   <= SIZE_WORD;
            a_own        <= OWN_NONE;
            d_own        <= OWN_NONE;
            last_d       <= 1'b0;
        end else begin
            pend_i       <= pend_i_nxt;
            pend_d       <= pend_d_nxt;
            buf_i_addr   <= buf_i_addr_nxt;
            buf_i_parity <= buf_i_parity_nxt;
            buf_d_addr   <= buf_d_addr_nxt;
            buf_d_parity <= buf_d_parity_nxt;
            buf_d_write  <= buf_d_write_nxt;
            buf_d_size   <= buf_d_size_nxt;
            a_own        <= a_own_nxt;
            d_own        <= d_own_nxt;
            last_d       <= last_d_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_dual_arbiter.sv
// Directed bench for ahb_dual_arbiter: fixed-priority instance plus round-robin instance on shared inputs.
// Expected slave grant addresses are queued when stimulus is driven and popped when the slave accepts.
module tb_ahb_dual_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] i_haddr, d_haddr, d_hwdata, hrdata;
    logic [1:0]  i_htrans, d_htrans;
    logic [5:0]  i_hparity, d_hparity;
    logic        d_hwrite, hready, hresp;
    logic [2:0]  d_hsize;
    logic [6:0]  d_hwchk, hrchk;

    logic        i_hready0, i_hresp0, d_hready0, d_hresp0, hwrite0;
    logic [31:0] i_hrdata0, d_hrdata0, haddr0, hwdata0;
    logic [6:0]  i_hrchk0, d_hrchk0, hwchk0;
    logic [1:0]  htrans0;
    logic [2:0]  hsize0;
    logic [5:0]  hparity0;

    logic        i_hready1, i_hresp1, d_hready1, d_hresp1, hwrite1;
    logic [31:0] i_hrdata1, d_hrdata1, haddr1, hwdata1;
    logic [6:0]  i_hrchk1, d_hrchk1, hwchk1;
    logic [1:0]  htrans1;
    logic [2:0]  hsize1;
    logic [5:0]  hparity1;

    ahb_dual_arbiter #(.ROUND_ROBIN(1'b0)) u_dut0 (
        .s_clk_i(clk), .s_resetn_i(rst_n),
        .s_i_haddr_i(i_haddr), .s_i_htrans_i(i_htrans), .s_i_hparity_i(i_hparity),
        .s_i_hready_o(i_hready0), .s_i_hresp_o(i_hresp0), .s_i_hrdata_o(i_hrdata0), .s_i_hrchecksum_o(i_hrchk0),
        .s_d_haddr_i(d_haddr), .s_d_htrans_i(d_htrans), .s_d_hwrite_i(d_hwrite), .s_d_hsize_i(d_hsize),
        .s_d_hparity_i(d_hparity), .s_d_hwdata_i(d_hwdata), .s_d_hwchecksum_i(d_hwchk),
        .s_d_hready_o(d_hready0), .s_d_hresp_o(d_hresp0), .s_d_hrdata_o(d_hrdata0), .s_d_hrchecksum_o(d_hrchk0),
        .s_haddr_o(haddr0), .s_htrans_o(htrans0), .s_hwrite_o(hwrite0), .s_hsize_o(hsize0),
        .s_hparity_o(hparity0), .s_hwdata_o(hwdata0), .s_hwchecksum_o(hwchk0),
        .s_hrdata_i(hrdata), .s_hrchecksum_i(hrchk), .s_hready_i(hready), .s_hresp_i(hresp)
    );

    ahb_dual_arbiter #(.ROUND_ROBIN(1'b1)) u_dut1 (
        .s_clk_i(clk), .s_resetn_i(rst_n),
        .s_i_haddr_i(i_haddr), .s_i_htrans_i(i_htrans), .s_i_hparity_i(i_hparity),
        .s_i_hready_o(i_hready1), .s_i_hresp_o(i_hresp1), .s_i_hrdata_o(i_hrdata1), .s_i_hrchecksum_o(i_hrchk1),
        .s_d_haddr_i(d_haddr), .s_d_htrans_i(d_htrans), .s_d_hwrite_i(d_hwrite), .s_d_hsize_i(d_hsize),
        .s_d_hparity_i(d_hparity), .s_d_hwdata_i(d_hwdata), .s_d_hwchecksum_i(d_hwchk),
        .s_d_hready_o(d_hready1), .s_d_hresp_o(d_hresp1), .s_d_hrdata_o(d_hrdata1), .s_d_hrchecksum_o(d_hrchk1),
        .s_haddr_o(haddr1), .s_htrans_o(htrans1), .s_hwrite_o(hwrite1), .s_hsize_o(hsize1),
        .s_hparity_o(hparity1), .s_hwdata_o(hwdata1), .s_hwchecksum_o(hwchk1),
        .s_hrdata_i(hrdata), .s_hrchecksum_i(hrchk), .s_hready_i(hready), .s_hresp_i(hresp)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb_q[$];
    bit          mon_sel = 1'b0;   // 0 = watch fixed-priority instance, 1 = round-robin instance

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_haddr = 32'd0; i_htrans = 2'b00; i_hparity = 6'd0;
        d_haddr = 32'd0; d_htrans = 2'b00; d_hwrite = 1'b0; d_hsize = 3'b010;
        d_hparity = 6'd0; d_hwdata = 32'd0; d_hwchk = 7'd0;
        hrdata = 32'd0; hrchk = 7'd0; hready = 1'b1; hresp = 1'b0;
    endtask

    // Move to the sampling point; a NONSEQ accepted by the slave pops the next expected grant
    task automatic settle();
        logic [1:0]  tr;
        logic [31:0] ad;
        @(negedge clk);
        tr = mon_sel ? htrans1 : htrans0;
        ad = mon_sel ? haddr1 : haddr0;
        if (rst_n && hready && tr == 2'b10) begin
            if (sb_q.size() == 0) chk("sb_underflow", 32'(sb_q.size()), 32'd1);
            else chk("sb_grant", ad, sb_q.pop_front());
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        adv();
        adv();
        rst_n = 1'b1;
    endtask

    logic [31:0] rr_ia[4];
    logic [31:0] rr_da[4];
    logic        rr_ir[4];
    logic        rr_dr[4];

    initial begin
        rst_n = 1'b0;
        idle();
        settle();
        chk("rst_htrans", 32'(htrans0), 32'd0);
        chk("rst_haddr", haddr0, 32'd0);
        chk("rst_hsize", 32'(hsize0), 32'd2);
        chk("rst_hwrite", 32'(hwrite0), 32'd0);
        chk("rst_hparity", 32'(hparity0), 32'd0);
        chk("rst_i_hready", 32'(i_hready0), 32'd1);
        chk("rst_d_hready", 32'(d_hready0), 32'd1);
        chk("rst_hresp", 32'({i_hresp0, d_hresp0}), 32'd0);
        adv();
        rst_n = 1'b1;
        adv();

        // Uncontended instruction read
        i_haddr = 32'h100; i_htrans = 2'b10; i_hparity = 6'h2A;
        sb_q.push_back(32'h100);
        settle();
        chk("t1_htrans", 32'(htrans0), 32'd2);
        chk("t1_haddr", haddr0, 32'h100);
        chk("t1_hparity", 32'(hparity0), 32'h2A);
        adv();
        idle(); hrdata = 32'hDEADBEEF;
        settle();
        chk("t1_i_hready", 32'(i_hready0), 32'd1);
        chk("t1_i_hrdata", i_hrdata0, 32'hDEADBEEF);
        chk("t1_d_hresp", 32'(d_hresp0), 32'd0);
        adv();

        // Simultaneous requests, fixed priority: D first, I buffered
        idle();
        i_haddr = 32'h200; i_htrans = 2'b10; i_hparity = 6'h15;
        d_haddr = 32'h3000; d_htrans = 2'b10; d_hwrite = 1'b1; d_hparity = 6'h0A;
        sb_q.push_back(32'h3000);
        sb_q.push_back(32'h200);
        settle();
        chk("t2_haddr_d", haddr0, 32'h3000);
        chk("t2_hwrite_d", 32'(hwrite0), 32'd1);
        chk("t2_hparity_d", 32'(hparity0), 32'h0A);
        adv();
        idle(); d_hwdata = 32'h55AA; d_hwchk = 7'h11;
        settle();
        chk("t2_haddr_i", haddr0, 32'h200);
        chk("t2_hwrite_i", 32'(hwrite0), 32'd0);
        chk("t2_hparity_i", 32'(hparity0), 32'h15);
        chk("t2_hwdata", hwdata0, 32'h55AA);
        chk("t2_hwchk", 32'(hwchk0), 32'h11);
        chk("t2_i_stall", 32'(i_hready0), 32'd0);
        adv();
        settle();
        chk("t2_i_release", 32'(i_hready0), 32'd1);
        chk("t2_hwdata_off", hwdata0, 32'd0);
        adv();

        // Round-robin instance under continuous contention: D, I, D, I
        do_reset();
        mon_sel = 1'b1;
        rr_ia = '{32'h1000, 32'h1004, 32'h1004, 32'h1008};
        rr_da = '{32'h2000, 32'h2004, 32'h2008, 32'h2008};
        rr_ir = '{1'b1, 1'b0, 1'b1, 1'b0};
        rr_dr = '{1'b1, 1'b1, 1'b0, 1'b1};
        sb_q.push_back(32'h2000);
        sb_q.push_back(32'h1000);
        sb_q.push_back(32'h2004);
        sb_q.push_back(32'h1004);
        sb_q.push_back(32'h2008);
        for (int c = 0; c < 4; c++) begin
            i_haddr = rr_ia[c]; i_htrans = 2'b10;
            d_haddr = rr_da[c]; d_htrans = 2'b10;
            settle();
            chk($sformatf("t3_i_hready_%0d", c), 32'(i_hready1), 32'(rr_ir[c]));
            chk($sformatf("t3_d_hready_%0d", c), 32'(d_hready1), 32'(rr_dr[c]));
            adv();
        end
        idle();
        settle();
        adv();
        mon_sel = 1'b0;

        // Slave wait states on D while I is accepted and held
        do_reset();
        d_haddr = 32'h40; d_htrans = 2'b10;
        sb_q.push_back(32'h40);
        settle();
        adv();
        idle(); hready = 1'b0;
        i_haddr = 32'h80; i_htrans = 2'b10;
        sb_q.push_back(32'h80);
        for (int c = 0; c < 3; c++) begin
            settle();
            chk($sformatf("t4_haddr_%0d", c), haddr0, 32'h80);
            chk($sformatf("t4_d_hready_%0d", c), 32'(d_hready0), 32'd0);
            if (c > 0) chk($sformatf("t4_i_hready_%0d", c), 32'(i_hready0), 32'd0);
            adv();
            i_htrans = 2'b00;
        end
        hready = 1'b1; hrdata = 32'h4040;
        settle();
        chk("t4_d_done", 32'(d_hready0), 32'd1);
        chk("t4_d_hrdata", d_hrdata0, 32'h4040);
        chk("t4_i_still", 32'(i_hready0), 32'd0);
        adv();
        idle();
        settle();
        chk("t4_i_done", 32'(i_hready0), 32'd1);
        adv();

        // Two-cycle error on D with I pending
        do_reset();
        i_haddr = 32'h300; i_htrans = 2'b10;
        d_haddr = 32'h400; d_htrans = 2'b10;
        sb_q.push_back(32'h400);
        sb_q.push_back(32'h300);
        settle();
        adv();
        idle(); hresp = 1'b1; hready = 1'b0;
        settle();
        chk("t5_d_hresp1", 32'(d_hresp0), 32'd1);
        chk("t5_i_hresp1", 32'(i_hresp0), 32'd0);
        chk("t5_d_hready1", 32'(d_hready0), 32'd0);
        adv();
        hready = 1'b1;
        settle();
        chk("t5_d_hresp2", 32'(d_hresp0), 32'd1);
        chk("t5_i_hresp2", 32'(i_hresp0), 32'd0);
        chk("t5_haddr_i", haddr0, 32'h300);
        chk("t5_htrans_i", 32'(htrans0), 32'd2);
        adv();
        idle();
        settle();
        chk("t5_d_hresp_off", 32'(d_hresp0), 32'd0);
        chk("t5_i_hready", 32'(i_hready0), 32'd1);
        adv();

        // Reset in the middle of a transfer with I pending
        i_haddr = 32'h500; i_htrans = 2'b10;
        d_haddr = 32'h600; d_htrans = 2'b10;
        sb_q.push_back(32'h600);
        settle();
        adv();
        idle();
        rst_n = 1'b0;
        settle();
        chk("t6_rst_htrans", 32'(htrans0), 32'd0);
        chk("t6_rst_i_hready", 32'(i_hready0), 32'd1);
        chk("t6_rst_d_hready", 32'(d_hready0), 32'd1);
        adv();
        rst_n = 1'b1;
        settle();
        chk("t6_post_htrans", 32'(htrans0), 32'd0);
        chk("t6_post_i_hready", 32'(i_hready0), 32'd1);
        adv();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
